// File: rtl/pc_run_monitor.sv
// pc_run_monitor: watches a core's PC/valid stream for per-PC hit counts, self-loop halt and watchdog, then holds a pass/fail verdict.
// Define PC_RUN_MONITOR_REG_CHECK_EN to also capture and compare a watched register's final write-back value.
module pc_run_monitor #(
    parameter int NUM_CH      = 4,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 16,
    parameter int CYC_W       = 24,
    parameter int TIMEOUT_CYC = 10000,
    parameter int HALT_REPS   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [PC_W-1:0]         i_pc,
    input  logic                    i_insn_vld,
    input  logic [NUM_CH*PC_W-1:0]  i_match_pc,
    input  logic [NUM_CH*CNT_W-1:0] i_exp_cnt,
    input  logic [NUM_CH-1:0]       i_ch_en,
    input  logic                    i_wb_en,
    input  logic [4:0]              i_wb_addr,
    input  logic [31:0]             i_wb_data,
    input  logic [4:0]              i_chk_reg,
    input  logic [31:0]             i_chk_val,
    output logic [NUM_CH*CNT_W-1:0] o_hit_cnt,
    output logic [CYC_W-1:0]        o_cyc_cnt,
    output logic [NUM_CH-1:0]       o_mismatch,
    output logic                    o_reg_mismatch,
    output logic                    o_done,
    output logic                    o_pass,
    output logic                    o_timeout
);
    localparam int REP_W = $clog2(HALT_REPS + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYC - 1);
    localparam logic [REP_W-1:0] REP_HALT = REP_W'(HALT_REPS);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_PASS, S_FAIL} state_t;

    state_t                    r_state, w_state_nxt;
    logic [NUM_CH*PC_W-1:0]    r_match_pc;
    logic [NUM_CH*CNT_W-1:0]   r_exp_cnt, r_cnt;
    logic [NUM_CH-1:0]         r_ch_en, r_mismatch;
    logic [CYC_W-1:0]          r_cyc;
    logic [PC_W-1:0]           r_prev_pc;
    logic [REP_W-1:0]          r_rep;
    logic                      r_reg_mismatch, r_done, r_pass, r_timeout;

    logic                      w_start, w_count, w_halt, w_timeout, w_rmm, w_ok;
    logic [NUM_CH*PC_W-1:0]    w_match_pc;
    logic [NUM_CH-1:0]         w_ch_en, w_hit, w_mm;
    logic [REP_W-1:0]          w_rep_nxt;

    // The start instruction is counted against the config being latched on the same edge.
    assign w_start    = (r_state == S_IDLE) && i_insn_vld;
    assign w_count    = w_start || (r_state == S_RUN);
    assign w_match_pc = w_start ? i_match_pc : r_match_pc;
    assign w_ch_en    = w_start ? i_ch_en : r_ch_en;
    assign w_rep_nxt  = (i_pc == r_prev_pc) ? r_rep + REP_W'(1) : REP_W'(1);
    assign w_halt     = (r_state == S_RUN) && i_insn_vld && (w_rep_nxt == REP_HALT);
    assign w_timeout  = (r_state == S_RUN) && !w_halt && (r_cyc == CYC_LAST);
    assign w_ok       = !(|w_mm) && !w_rmm;

    always_comb begin
        w_hit = '0;
        w_mm  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_hit[k] = i_insn_vld && w_ch_en[k] && (i_pc == w_match_pc[k*PC_W +: PC_W]);
            w_mm[k]  = r_ch_en[k] && (r_cnt[k*CNT_W +: CNT_W] != r_exp_cnt[k*CNT_W +: CNT_W]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = i_insn_vld ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_halt ? S_CHECK : (w_timeout ? S_FAIL : S_RUN);
            S_CHECK: w_state_nxt = w_ok ? S_PASS : S_FAIL;
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_match_pc     <= '0;
            r_exp_cnt      <= '0;
            r_ch_en        <= '0;
            r_cnt          <= '0;
            r_cyc          <= '0;
            r_prev_pc      <= '0;
            r_rep          <= '0;
            r_mismatch     <= '0;
            r_reg_mismatch <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            if (w_start) begin
                r_match_pc <= i_match_pc;
                r_exp_cnt  <= i_exp_cnt;
                r_ch_en    <= i_ch_en;
                r_prev_pc  <= i_pc;
                r_rep      <= REP_W'(1);
            end else if ((r_state == S_RUN) && i_insn_vld) begin
                r_prev_pc  <= i_pc;
                r_rep      <= w_rep_nxt;
            end
            if (w_count)
                for (int k = 0; k < NUM_CH; k++)
                    if (w_hit[k] && (r_cnt[k*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
                        r_cnt[k*CNT_W +: CNT_W] <= r_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
            if ((r_state == S_RUN) && (r_cyc != {CYC_W{1'b1}}))
                r_cyc <= r_cyc + CYC_W'(1);
            if (w_timeout) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
            end
            if (r_state == S_CHECK) begin
                r_mismatch     <= w_mm;
                r_reg_mismatch <= w_rmm;
                r_done         <= 1'b1;
                r_pass         <= w_ok;
            end
        end
    end

`ifdef PC_RUN_MONITOR_REG_CHECK_EN
    logic [4:0]  r_chk_reg, w_chk_reg;
    logic [31:0] r_chk_val, r_last_val;

    assign w_chk_reg = w_start ? i_chk_reg : r_chk_reg;
    assign w_rmm     = (r_last_val != r_chk_val);

    // With x0 watched nothing is ever captured, so last_val stays at its reset 0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_chk_reg  <= '0;
            r_chk_val  <= '0;
            r_last_val <= '0;
        end else begin
            if (w_start) begin
                r_chk_reg <= i_chk_reg;
                r_chk_val <= i_chk_val;
            end
            if (w_count && i_wb_en && (i_wb_addr == w_chk_reg) && (w_chk_reg != 5'd0))
                r_last_val <= i_wb_data;
        end
    end
`else
    logic w_unused;
    assign w_rmm    = 1'b0;
    assign w_unused = ^{i_wb_en, i_wb_addr, i_wb_data, i_chk_reg, i_chk_val};
`endif

    assign o_hit_cnt      = r_cnt;
    assign o_cyc_cnt      = r_cyc;
    assign o_mismatch     = r_mismatch;
    assign o_reg_mismatch = r_reg_mismatch;
    assign o_done         = r_done;
    assign o_pass         = r_pass;
    assign o_timeout      = r_timeout;
endmodule

// File: tb/tb_pc_run_monitor.sv
// tb_pc_run_monitor: directed checks of pc_run_monitor; u_a uses wide counters and a long watchdog,
// u_b uses 4-bit counters and a 100-cycle watchdog, both fed the same instruction stream.
module tb_pc_run_monitor;
`ifdef PC_RUN_MONITOR_REG_CHECK_EN
    localparam logic REG_EN = 1'b1;
`else
    localparam logic REG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pc;
    logic        i_insn_vld;
    logic [127:0] i_match_pc;
    logic [63:0] exp_a;
    logic [15:0] exp_b;
    logic [3:0]  i_ch_en;
    logic        i_wb_en;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic [4:0]  i_chk_reg;
    logic [31:0] i_chk_val;

    logic [63:0] hit_a;
    logic [15:0] hit_b;
    logic [23:0] cyc_a, cyc_b;
    logic [3:0]  mm_a, mm_b;
    logic        rmm_a, rmm_b, done_a, done_b, pass_a, pass_b, to_a, to_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_run_monitor #(.NUM_CH(4), .PC_W(32), .CNT_W(16), .CYC_W(24), .TIMEOUT_CYC(10000), .HALT_REPS(4)) u_a (
        .i_clk(clk), .i_reset(i_reset), .i_pc(i_pc), .i_insn_vld(i_insn_vld),
        .i_match_pc(i_match_pc), .i_exp_cnt(exp_a), .i_ch_en(i_ch_en),
        .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_chk_reg(i_chk_reg), .i_chk_val(i_chk_val),
        .o_hit_cnt(hit_a), .o_cyc_cnt(cyc_a), .o_mismatch(mm_a), .o_reg_mismatch(rmm_a),
        .o_done(done_a), .o_pass(pass_a), .o_timeout(to_a)
    );

    pc_run_monitor #(.NUM_CH(4), .PC_W(32), .CNT_W(4), .CYC_W(24), .TIMEOUT_CYC(100), .HALT_REPS(4)) u_b (
        .i_clk(clk), .i_reset(i_reset), .i_pc(i_pc), .i_insn_vld(i_insn_vld),
        .i_match_pc(i_match_pc), .i_exp_cnt(exp_b), .i_ch_en(i_ch_en),
        .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_chk_reg(i_chk_reg), .i_chk_val(i_chk_val),
        .o_hit_cnt(hit_b), .o_cyc_cnt(cyc_b), .o_mismatch(mm_b), .o_reg_mismatch(rmm_b),
        .o_done(done_b), .o_pass(pass_b), .o_timeout(to_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        i_insn_vld = v;
        i_pc       = pc;
        i_wb_en    = we;
        i_wb_addr  = wa;
        i_wb_data  = wd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    // Sum 1..n: x11=1, x12=51, loop {add x10 @0x08; addi x11 @0x0c; bne @0x10}, then j . at 0x14.
    task automatic sum_prog(input int n, input bit fin, input bit scramble);
        int s;
        s = 0;
        step(1'b1, 32'h00, 1'b1, 5'd11, 32'd1);
        if (scramble) begin
            i_match_pc[31:0] = 32'h100;
            exp_a[15:0]      = 16'd7;
            i_ch_en          = 4'b1111;
            i_chk_val        = 32'd0;
        end
        step(1'b1, 32'h04, 1'b1, 5'd12, 32'd51);
        for (int i = 1; i <= n; i++) begin
            s += i;
            step(1'b1, 32'h08, 1'b1, 5'd10, s);
            step(1'b1, 32'h0c, 1'b1, 5'd11, i + 1);
            step(1'b1, 32'h10, 1'b0, 5'd0, 32'd0);
        end
        if (fin) begin
            for (int i = 0; i < 4; i++) step(1'b1, 32'h14, 1'b0, 5'd0, 32'd0);
            chk("sum_check_state_not_done", done_a, 0);
            step(1'b1, 32'h14, 1'b0, 5'd0, 32'd0);
        end
    endtask

    task automatic sum_cfg(input logic [15:0] e0, input logic [31:0] cv);
        i_match_pc = '0;
        i_match_pc[31:0] = 32'h08;
        exp_a = '0;
        exp_a[15:0] = e0;
        i_ch_en = 4'b0001;
        i_chk_reg = 5'd10;
        i_chk_val = cv;
    endtask

    initial begin
        i_reset = 1'b1;
        i_pc = '0; i_insn_vld = 1'b0; i_match_pc = '0; exp_a = '0; exp_b = '0; i_ch_en = '0;
        i_wb_en = 1'b0; i_wb_addr = '0; i_wb_data = '0; i_chk_reg = '0; i_chk_val = '0;
        #1;
        chk("reset_hit", hit_a, 0);
        chk("reset_flags", {cyc_a, mm_a, rmm_a, done_a, pass_a, to_a}, 0);
        @(negedge clk);
        i_reset = 1'b0;

        // Passing sum run
        sum_cfg(16'd50, 32'd1275);
        sum_prog(50, 1'b1, 1'b0);
        chk("sum_done", done_a, 1);
        chk("sum_pass", pass_a, 1);
        chk("sum_hit0", hit_a[15:0], 50);
        chk("sum_mismatch", mm_a, 0);
        chk("sum_reg_mismatch", rmm_a, 0);
        chk("sum_timeout", to_a, 0);
        chk("sum_cyc", cyc_a, 155);

        // Same run with wrong expectations
        do_reset();
        sum_cfg(16'd49, 32'd1276);
        sum_prog(50, 1'b1, 1'b0);
        chk("bad_done", done_a, 1);
        chk("bad_pass", pass_a, 0);
        chk("bad_mismatch", mm_a, 4'b0001);
        chk("bad_reg_mismatch", rmm_a, REG_EN);
        chk("bad_timeout", to_a, 0);

        // Reset mid-run after 30 hits, then clean rerun with inputs scrambled after start
        do_reset();
        sum_cfg(16'd50, 32'd1275);
        sum_prog(30, 1'b0, 1'b0);
        chk("mid_hit30", hit_a[15:0], 30);
        i_reset = 1'b1;
        #1;
        chk("mid_reset_hit", hit_a, 0);
        chk("mid_reset_flags", {cyc_a, mm_a, rmm_a, done_a, pass_a, to_a}, 0);
        @(negedge clk);
        i_reset = 1'b0;
        sum_prog(50, 1'b1, 1'b1);
        chk("rerun_pass", {done_a, pass_a, to_a}, 3'b110);
        chk("rerun_hit0", hit_a[15:0], 50);
        chk("rerun_mismatch", {mm_a, rmm_a}, 0);

        // Watchdog on u_b: PC walks by 4, never repeats
        do_reset();
        i_ch_en = 4'b0000; i_chk_reg = 5'd0; i_chk_val = 32'd0; exp_b = '0;
        for (int i = 0; i < 100; i++) step(1'b1, 32'(i * 4), 1'b0, 5'd0, 32'd0);
        chk("to_pre_cyc", cyc_b, 99);
        chk("to_pre_done", {done_b, to_b}, 0);
        step(1'b1, 32'd400, 1'b0, 5'd0, 32'd0);
        chk("to_flags", {done_b, pass_b, to_b}, 3'b101);
        chk("to_mismatch", {mm_b, rmm_b}, 0);
        chk("to_cyc", cyc_b, 100);

        // Halt completing on the timeout cycle wins
        do_reset();
        for (int i = 0; i < 97; i++) step(1'b1, 32'(i * 4), 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h1000, 1'b0, 5'd0, 32'd0);
        chk("race_check_state", {done_b, to_b}, 0);
        step(1'b0, 32'h0, 1'b0, 5'd0, 32'd0);
        chk("race_flags", {done_b, pass_b, to_b}, 3'b110);
        chk("race_cyc", cyc_b, 100);

        // Saturation on u_b channel 1
        do_reset();
        i_match_pc = '0; i_match_pc[63:32] = 32'h40;
        exp_b = '0; exp_b[7:4] = 4'd15;
        i_ch_en = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h40, 1'b0, 5'd0, 32'd0);
            step(1'b1, 32'h44, 1'b0, 5'd0, 32'd0);
        end
        chk("sat_hit1_live", hit_b, 16'h00f0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h80, 1'b0, 5'd0, 32'd0);
        chk("sat_hit1", hit_b[7:4], 15);
        chk("sat_flags", {done_b, pass_b, to_b}, 3'b110);
        chk("sat_mismatch", mm_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "bench timeout");
    end
endmodule
